// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice datapath: envelope states and
// level scaling constants.
package synth_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  // Full-scale envelope level and the shift that maps level to unity gain.
  localparam logic [15:0] ENV_MAX   = 16'hFFFF;
  localparam int          ENV_SHIFT = 16;

endpackage

// File: rtl/env_vca.sv
// Registered signed amplitude scaler: sample_out = (sample_in * level) >>> 16,
// updated once per step_in tick, with a one-cycle valid pulse.
module env_vca
  import synth_pkg::*;
#(
  parameter int LEVEL_W = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      step_in,
  input  logic signed [31:0]        sample_in,
  input  logic        [LEVEL_W-1:0] level,
  output logic signed [31:0]        sample_out,
  output logic                      valid_out
);

  localparam int PROD_W = 32 + LEVEL_W + 1;

  // The level is zero-extended so the multiply stays signed without
  // treating full-scale levels as negative.
  logic signed [LEVEL_W:0]   level_s;
  logic signed [PROD_W-1:0]  product;
  logic                      unused_product_bits;

  assign level_s = $signed({1'b0, level});
  assign product = sample_in * level_s;

  // Bits above the result window are redundant sign bits; the low bits are
  // the truncated fraction (arithmetic shift rounds toward minus infinity).
  assign unused_product_bits = ^{product[PROD_W-1:ENV_SHIFT+32], product[ENV_SHIFT-1:0]};

  // Output register: capture the scaled sample on each tick, pulse valid.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sample_out <= '0;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= step_in;
      if (step_in) begin
        sample_out <= product[ENV_SHIFT+31:ENV_SHIFT];
      end
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator. Gate edges steer the state machine on
// every clock; level arithmetic advances only on step_in ticks without a gate
// edge. The oscillator sample is scaled by the pre-update level of each tick.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int LEVEL_W = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      step_in,
  input  logic                      gate_in,
  input  logic        [LEVEL_W-1:0] attack_rate_in,
  input  logic        [LEVEL_W-1:0] decay_rate_in,
  input  logic        [LEVEL_W-1:0] sustain_level_in,
  input  logic        [LEVEL_W-1:0] release_rate_in,
  input  logic signed [31:0]        sample_in,
  output logic signed [31:0]        sample_out,
  output logic                      valid_out,
  output logic        [LEVEL_W-1:0] env_out,
  output logic                      active_out
);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(ENV_MAX);

  env_state_t         state_reg, state_next;
  logic [LEVEL_W-1:0] level_reg, level_next;
  logic               gate_q;
  logic               gate_rise, gate_fall;

  // Attack sum carries one extra bit so overflow past full scale is visible;
  // decay difference carries a sign bit so it can go below zero without wrap.
  logic        [LEVEL_W:0]   attack_sum;
  logic signed [LEVEL_W+1:0] decay_diff;
  logic signed [LEVEL_W+1:0] sustain_s;

  assign gate_rise  = gate_in & ~gate_q;
  assign gate_fall  = ~gate_in & gate_q;
  assign attack_sum = {1'b0, level_reg} + {1'b0, attack_rate_in};
  assign decay_diff = $signed({2'b00, level_reg}) - $signed({2'b00, decay_rate_in});
  assign sustain_s  = $signed({2'b00, sustain_level_in});

  // State, level and gate history registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg <= IDLE;
      level_reg <= '0;
      gate_q    <= 1'b0;
    end else begin
      state_reg <= state_next;
      level_reg <= level_next;
      gate_q    <= gate_in;
    end
  end

  // Next-state and level update: a gate edge takes priority and freezes the
  // level for that cycle; otherwise a tick advances the current phase.
  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    if (gate_rise) begin
      state_next = ATTACK;
    end else if (gate_fall) begin
      if (state_reg == ATTACK || state_reg == DECAY || state_reg == SUSTAIN) begin
        state_next = RELEASE;
      end
    end else if (step_in) begin
      case (state_reg)
        IDLE: begin
          level_next = '0;
        end
        ATTACK: begin
          if (attack_sum >= {1'b0, LEVEL_MAX}) begin
            level_next = LEVEL_MAX;
            state_next = DECAY;
          end else begin
            level_next = attack_sum[LEVEL_W-1:0];
          end
        end
        DECAY: begin
          if (decay_diff <= sustain_s) begin
            level_next = sustain_level_in;
            state_next = SUSTAIN;
          end else begin
            level_next = decay_diff[LEVEL_W-1:0];
          end
        end
        SUSTAIN: begin
          level_next = sustain_level_in;
        end
        RELEASE: begin
          if (level_reg <= release_rate_in) begin
            level_next = '0;
            state_next = IDLE;
          end else begin
            level_next = level_reg - release_rate_in;
          end
        end
        default: begin
          level_next = '0;
          state_next = IDLE;
        end
      endcase
    end
  end

  assign env_out    = level_reg;
  assign active_out = (state_reg != IDLE);

  env_vca #(
    .LEVEL_W (LEVEL_W)
  ) u_vca (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .step_in    (step_in),
    .sample_in  (sample_in),
    .level      (level_reg),
    .sample_out (sample_out),
    .valid_out  (valid_out)
  );

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: a behavioural envelope model pushes the
// expected result of each tick into a scoreboard, popped when valid_out fires.
module tb_adsr_envelope;
  import synth_pkg::*;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic               step_in = 1'b0;
  logic               gate_in = 1'b0;
  logic        [15:0] attack_rate_in = '0;
  logic        [15:0] decay_rate_in = '0;
  logic        [15:0] sustain_level_in = '0;
  logic        [15:0] release_rate_in = '0;
  logic signed [31:0] sample_in = '0;
  logic signed [31:0] sample_out;
  logic               valid_out;
  logic        [15:0] env_out;
  logic               active_out;

  adsr_envelope #(.LEVEL_W(16)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .step_in          (step_in),
    .gate_in          (gate_in),
    .attack_rate_in   (attack_rate_in),
    .decay_rate_in    (decay_rate_in),
    .sustain_level_in (sustain_level_in),
    .release_rate_in  (release_rate_in),
    .sample_in        (sample_in),
    .sample_out       (sample_out),
    .valid_out        (valid_out),
    .env_out          (env_out),
    .active_out       (active_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] sample;
    logic [15:0] env;
    logic        active;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  env_state_t m_state = IDLE;
  int         m_level = 0;
  logic       m_gq = 1'b0;
  logic       rand_sample = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // (x * level) >>> 16 with floor rounding, in wide integer arithmetic.
  function automatic logic [31:0] scale(input logic signed [31:0] x, input logic [15:0] l);
    longint p;
    p = longint'(x) * longint'({1'b0, l});
    p = p >>> 16;
    return p[31:0];
  endfunction

  // One tick of envelope arithmetic, written from the phase descriptions.
  task automatic model_step();
    int atk, dec, sus, rel;
    atk = int'(attack_rate_in);
    dec = int'(decay_rate_in);
    sus = int'(sustain_level_in);
    rel = int'(release_rate_in);
    case (m_state)
      IDLE: m_level = 0;
      ATTACK: begin
        if (m_level + atk >= 65535) begin
          m_level = 65535;
          m_state = DECAY;
        end else m_level = m_level + atk;
      end
      DECAY: begin
        if (m_level - dec <= sus) begin
          m_level = sus;
          m_state = SUSTAIN;
        end else m_level = m_level - dec;
      end
      SUSTAIN: m_level = sus;
      RELEASE: begin
        if (m_level <= rel) begin
          m_level = 0;
          m_state = IDLE;
        end else m_level = m_level - rel;
      end
      default: m_level = 0;
    endcase
  endtask

  // Drive one clock cycle with the given gate and step, model it, and check.
  task automatic cycle(input logic g, input logic s);
    exp_t        e;
    exp_t        got;
    logic [15:0] pre;
    logic        rise, fall;
    @(negedge clk_in);
    rst_in  = 1'b0;
    gate_in = g;
    step_in = s;
    if (rand_sample) sample_in = $signed($urandom);
    pre  = m_level[15:0];
    rise = g & ~m_gq;
    fall = ~g & m_gq;
    m_gq = g;
    if (rise) m_state = ATTACK;
    else if (fall) begin
      if (m_state inside {ATTACK, DECAY, SUSTAIN}) m_state = RELEASE;
    end else if (s) model_step();
    if (s) begin
      e.sample = scale(sample_in, pre);
      e.env    = m_level[15:0];
      e.active = (m_state != IDLE);
      sb.push_back(e);
    end
    @(posedge clk_in);
    #1;
    check("valid", {31'b0, valid_out}, {31'b0, s});
    check("active", {31'b0, active_out}, {31'b0, (m_state != IDLE)});
    check("env_cycle", {16'b0, env_out}, m_level);
    if (valid_out && sb.size() > 0) begin
      got = sb.pop_front();
      check("sb_sample", sample_out, got.sample);
      check("sb_env", {16'b0, env_out}, {16'b0, got.env});
      check("sb_active", {31'b0, active_out}, {31'b0, got.active});
      $display("[TB] tick gate=%0b env=%h sample=%0d active=%0b", g, env_out, sample_out, active_out);
    end
  endtask

  task automatic do_reset(input logic g);
    @(negedge clk_in);
    rst_in  = 1'b1;
    gate_in = g;
    step_in = 1'b0;
    @(posedge clk_in);
    #1;
    check("rst_sample", sample_out, 32'h0);
    check("rst_valid", {31'b0, valid_out}, 32'h0);
    check("rst_env", {16'b0, env_out}, 32'h0);
    check("rst_active", {31'b0, active_out}, 32'h0);
    m_state = IDLE;
    m_level = 0;
    m_gq    = 1'b0;
    sb.delete();
    $display("[TB] reset gate=%0b", g);
  endtask

  task automatic release_to_idle();
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 40 && m_state != IDLE; i++) cycle(1'b0, 1'b1);
  endtask

  initial begin
    do_reset(1'b0);

    // Attack / decay / sustain with a fixed -128 sample.
    attack_rate_in   = 16'h4000;
    decay_rate_in    = 16'h1000;
    sustain_level_in = 16'h8000;
    release_rate_in  = 16'h3000;
    sample_in        = -32'sd128;
    cycle(1'b1, 1'b0);
    check("attack_entry_env", {16'b0, env_out}, 32'h0);
    cycle(1'b1, 1'b1);
    check("attack1_env", {16'b0, env_out}, 32'h4000);
    check("scale_level0", sample_out, 32'h0);
    cycle(1'b1, 1'b0);
    check("valid_single_pulse", {31'b0, valid_out}, 32'h0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    check("attack3_env", {16'b0, env_out}, 32'hC000);
    cycle(1'b1, 1'b1);
    check("attack_clip", {16'b0, env_out}, 32'hFFFF);
    cycle(1'b1, 1'b1);
    check("decay1_env", {16'b0, env_out}, 32'hEFFF);
    check("scale_full", sample_out, 32'hFFFF_FF80);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1);
    check("decay_last", {16'b0, env_out}, 32'h8FFF);
    cycle(1'b1, 1'b1);
    check("sustain_entry", {16'b0, env_out}, 32'h8000);
    cycle(1'b1, 1'b1);
    check("scale_half", sample_out, 32'hFFFF_FFC0);

    // Release from sustain.
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check("release1", {16'b0, env_out}, 32'h5000);
    cycle(1'b0, 1'b1);
    check("release2", {16'b0, env_out}, 32'h2000);
    check("release2_active", {31'b0, active_out}, 32'h1);
    cycle(1'b0, 1'b1);
    check("release_end", {16'b0, env_out}, 32'h0);
    check("release_end_active", {31'b0, active_out}, 32'h0);
    cycle(1'b0, 1'b1);
    check("idle_scale", sample_out, 32'h0);

    // Retrigger from RELEASE at 0x3000; edge cycles coincide with ticks.
    rand_sample    = 1'b1;
    attack_rate_in = 16'h3000;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    check("release_hold_on_edge", {16'b0, env_out}, 32'h3000);
    cycle(1'b1, 1'b1);
    check("retrigger_hold", {16'b0, env_out}, 32'h3000);
    cycle(1'b1, 1'b1);
    check("retrigger_resume", {16'b0, env_out}, 32'h6000);
    release_to_idle();

    // Zero attack rate holds level 0 in ATTACK.
    attack_rate_in = 16'h0000;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1);
    check("zero_attack_env", {16'b0, env_out}, 32'h0);
    check("zero_attack_active", {31'b0, active_out}, 32'h1);
    cycle(1'b0, 1'b0);
    release_to_idle();

    // Sustain at full scale: decay exits on its first tick, then track live sustain.
    attack_rate_in   = 16'hFFFF;
    sustain_level_in = 16'hFFFF;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    check("full_attack", {16'b0, env_out}, 32'hFFFF);
    cycle(1'b1, 1'b1);
    check("decay_exit_first", {16'b0, env_out}, 32'hFFFF);
    sustain_level_in = 16'h4000;
    cycle(1'b1, 1'b1);
    check("sustain_track_lo", {16'b0, env_out}, 32'h4000);
    sustain_level_in = 16'h9000;
    cycle(1'b1, 1'b1);
    check("sustain_track_hi", {16'b0, env_out}, 32'h9000);
    release_to_idle();

    // Reset mid-note at 0xC000 with the gate still high.
    attack_rate_in = 16'h4000;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    check("pre_reset_env", {16'b0, env_out}, 32'hC000);
    do_reset(1'b1);
    cycle(1'b1, 1'b0);
    check("post_reset_attack", {31'b0, active_out}, 32'h1);
    check("post_reset_env", {16'b0, env_out}, 32'h0);
    cycle(1'b1, 1'b1);
    check("post_reset_step", {16'b0, env_out}, 32'h4000);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Per-voice ADSR envelope generator and amplitude scaler that sits directly downstream of the oscillator stage (triangle/sine generators). It consumes the oscillator's signed 32-bit sample and a gate, advances a 16-bit envelope level once per `step_in` sample tick, and outputs the sample scaled by the envelope to the voice mixer.

## Interface
- `LEVEL_W`, 16: envelope level width; full scale is `2^LEVEL_W-1`.
- `clk_in` input 1: system clock.
- `rst_in` input 1: reset, synchronous, active-high.
- `step_in` input 1: sample tick, the same strobe that steps the oscillator.
- `gate_in` input 1: note on (1) / note off (0), level-sensitive.
- `attack_rate_in` input 16: level increment per tick in ATTACK.
- `decay_rate_in` input 16: level decrement per tick in DECAY.
- `sustain_level_in` input 16: SUSTAIN target level.
- `release_rate_in` input 16: level decrement per tick in RELEASE.
- `sample_in` input 32 signed: oscillator output.
- `sample_out` output 32 signed: `(sample_in * level) >>> 16`.
- `valid_out` output 1: one-cycle pulse when `sample_out` updates.
- `env_out` output 16: current envelope level.
- `active_out` output 1: high whenever state is not IDLE.

## Operation
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. Reset state is IDLE with level 0.
- Gate edge detection uses a registered `gate_q` and is evaluated every clock, independent of `step_in`.
- A rising edge of `gate_in` in any state moves the block to ATTACK. This is a retrigger: the level is kept, not zeroed.
- A falling edge in ATTACK, DECAY or SUSTAIN moves the block to RELEASE. A falling edge in IDLE or RELEASE has no effect.
- Level arithmetic is performed only on a cycle with `step_in=1` and no gate edge. A gate edge wins: the state changes and the level holds that cycle.
- ATTACK: `level += attack_rate` using a 17-bit sum. If the sum is ≥ 0xFFFF, set level = 0xFFFF and move to DECAY.
- DECAY: if `level - decay_rate ≤ sustain`, set level = sustain and move to SUSTAIN. Otherwise subtract. Compute as signed 17-bit so there is no wrap.
- SUSTAIN: level = `sustain_level_in`, sampled on each tick, so live changes are tracked.
- RELEASE: if `level ≤ release_rate`, set level = 0 and move to IDLE. Otherwise subtract.
- IDLE: level held at 0.
- A rate of 0 holds the level in that state indefinitely; this is legal.
- Sustain = 0xFFFF: DECAY exits on its first tick.
- Sustain = 0: a held note decays to silence but stays in SUSTAIN with `active_out=1`.
- Scaling: 32×17 signed multiply of `sample_in` by `{1'b0, level}`. Take product bits [47:16], i.e. an arithmetic shift by 16, truncating toward −∞. The multiply uses the pre-update level of the same tick.

## Timing
- Reset values: `sample_out=0`, `valid_out=0`, `env_out=0`, `active_out=0`, `gate_q=0`.
- If reset is asserted mid-note, all outputs return to these values on the next edge. A gate held high through reset release is then seen as a rising edge, and ATTACK is entered one cycle after `rst_in` falls.
- Latency: `step_in` at cycle N gives registered `sample_out` and `env_out` (post-update level) plus `valid_out=1` at N+1. `valid_out` is a single-cycle pulse.
- Back-to-back `step_in` on consecutive cycles is supported, with one result per tick.
- A gate edge is visible in state one cycle after the `gate_in` change. `active_out` follows state with no extra latency.
- Single-cycle path: one multiplier stage. The multiply is registered at the output.

## Structure
- Shared package `synth_pkg`:
  - `env_state_t` enum (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE).
  - `ENV_MAX = 16'hFFFF`.
  - `ENV_SHIFT = 16`.
- Sub-module `env_vca`: registered signed scaler taking `sample_in`, `level` and `step_in`, and producing `sample_out` and `valid_out`.
- The FSM and level arithmetic stay in `adsr_envelope`.

## Test plan
- Attack, decay, sustain: gate=1, attack=0x4000, decay=0x1000, sustain=0x8000, step every cycle.
  - `env_out` goes 0x4000, 0x8000, 0xC000, 0xFFFF (then DECAY), 0xEFFF … 0x8FFF, 0x8000 (then SUSTAIN).
- Release: from SUSTAIN 0x8000 with release=0x3000, drop the gate.
  - Level goes 0x5000, 0x2000, 0 (then IDLE); `active_out` falls with that last step.
- Scaling with `sample_in=-128`:
  - level 0xFFFF: `sample_out = -128`.
  - level 0x8000: `sample_out = -64`.
  - level 0: `sample_out = 0`.
  - `valid_out` pulses exactly one cycle after each `step_in`.
- Retrigger: gate 1→0→1 while in RELEASE at 0x3000.
  - ATTACK resumes from 0x3000, not from 0.
  - On a cycle where gate edge and `step_in` coincide, the level holds.
- Zero-rate boundaries:
  - attack=0 holds level 0 in ATTACK for 100 ticks.
  - sustain=0xFFFF: DECAY exits on its first tick.
  - Changing `sustain_level_in` in SUSTAIN: `env_out` tracks it on the next tick.
- Reset mid-note at level 0xC000 with gate still high: outputs go to 0 and state to IDLE, then ATTACK starts the cycle after reset release.
